// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and its enum view.
package adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_e;

endpackage

// File: rtl/fa_slice.sv
// Single-bit full adder; the one arithmetic slice the serial adder reuses every cycle.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full-adder slice, LSB first, one bit per clock,
// with registered sum/cout that only update on completion.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_sum, fa_cout;
    logic               last_bit;

    fa_slice u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (last_bit) begin
                    // The final slice bit completes the result this edge, so publish it directly.
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
        res_q  <= res_d;
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a WIDTH=4 instance and a WIDTH=2 board-build instance.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       reset;
    logic       start4, start2;
    logic [3:0] a4, b4;
    logic [1:0] a2, b2;
    logic [3:0] sum4;
    logic [1:0] sum2;
    logic       cout4, busy4, done4;
    logic       cout2, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
        .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=4 addition with a start pulse; checks busy phase, done pulse and hold.
    task automatic add4(input logic [3:0] ia, input logic [3:0] ib,
                        input logic [3:0] old_s, input logic old_c,
                        input logic [3:0] exp_s, input logic exp_c, input string tag);
        a4 = ia; b4 = ib; start4 = 1'b1;
        step();
        start4 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, busy4, 1'b1);
            chk({tag, "_nodone"}, done4, 1'b0);
            chk({tag, "_hold_sum"}, sum4, old_s);
            chk({tag, "_hold_cout"}, cout4, old_c);
            if (i < 3) step();
        end
        step();
        chk({tag, "_done"}, done4, 1'b1);
        chk({tag, "_busy_off"}, busy4, 1'b0);
        chk({tag, "_sum"}, sum4, exp_s);
        chk({tag, "_cout"}, cout4, exp_c);
        step();
        chk({tag, "_done_fall"}, done4, 1'b0);
        chk({tag, "_sum_held"}, sum4, exp_s);
    endtask

    initial begin
        reset = 1'b1; start4 = 1'b0; start2 = 1'b0;
        a4 = '0; b4 = '0; a2 = '0; b2 = '0;
        step(); step();
        chk("rst_sum", sum4, 4'd0);
        chk("rst_cout", cout4, 1'b0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst2_sum", sum2, 2'd0);
        chk("rst2_busy", busy2, 1'b0);
        reset = 1'b0;
        step();

        add4(4'd3,  4'd5,  4'd0, 1'b0, 4'd8,  1'b0, "a3b5");
        add4(4'd15, 4'd1,  4'd8, 1'b0, 4'd0,  1'b1, "a15b1");
        add4(4'd15, 4'd15, 4'd0, 1'b1, 4'd14, 1'b1, "a15b15");

        // Start requests during RUN and DONE must be ignored.
        a4 = 4'd2; b4 = 4'd1; start4 = 1'b1;
        step();
        a4 = 4'd15; b4 = 4'd15;
        for (int i = 0; i < 4; i++) begin
            chk("ign_busy", busy4, 1'b1);
            step();
        end
        chk("ign_done", done4, 1'b1);
        chk("ign_sum", sum4, 4'd3);
        chk("ign_cout", cout4, 1'b0);
        step();
        start4 = 1'b0;
        chk("ign_done_fall", done4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ign_no_redone", done4, 1'b0);
            chk("ign_no_rebusy", busy4, 1'b0);
        end
        chk("ign_sum_held", sum4, 4'd3);

        // Reset in the second RUN cycle aborts and clears outputs.
        a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy4, 1'b0);
        chk("mid_rst_done", done4, 1'b0);
        chk("mid_rst_sum", sum4, 4'd0);
        chk("mid_rst_cout", cout4, 1'b0);
        step();
        chk("mid_rst_idle", busy4, 1'b0);
        add4(4'd9, 4'd9, 4'd0, 1'b0, 4'd2, 1'b1, "a9b9");

        // Continuous start: one result every 6 cycles.
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            chk("bb_busy", busy4, ((c % 6) < 4) ? 1'b1 : 1'b0);
            chk("bb_done", done4, ((c % 6) == 4) ? 1'b1 : 1'b0);
            chk("bb_overlap", busy4 & done4, 1'b0);
            if ((c % 6) == 4) begin
                chk("bb_sum", sum4, 4'd2);
                chk("bb_cout", cout4, 1'b0);
            end
        end
        start4 = 1'b0;
        step(); step();

        // WIDTH=2 board build.
        a2 = 2'd3; b2 = 2'd3; start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("w2_busy0", busy2, 1'b1);
        chk("w2_sum_hold", sum2, 2'd0);
        step();
        chk("w2_busy1", busy2, 1'b1);
        chk("w2_nodone", done2, 1'b0);
        step();
        chk("w2_done", done2, 1'b1);
        chk("w2_busy_off", busy2, 1'b0);
        chk("w2_sum", sum2, 2'd2);
        chk("w2_cout", cout2, 1'b1);
        step();
        chk("w2_done_fall", done2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
